// File: rtl/button_debouncer_if.sv
// Push-button bundle between raw switch inputs and the debounced event outputs.
interface button_debouncer_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw_n;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             busy;

    modport master (
        output btn_raw_n,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  busy
    );

    modport slave (
        input  btn_raw_n,
        output btn_level,
        output btn_press,
        output btn_release,
        output busy
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchroniser, then a per-channel
// stability-counting FSM producing a registered level and one-cycle press/release pulses.
module button_debouncer #(
    parameter int unsigned N_BTN        = 3,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned STABLE_COUNT = 50000
) (
    input logic               clock,
    input logic               reset,
    button_debouncer_if.slave bus
);
    typedef enum logic [1:0] {
        StReleased,
        StWaitPress,
        StPressed,
        StWaitRelease
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] cnt_nz;

    // Idle level of an active-low button is 1, so reset the synchroniser high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.btn_raw_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 press_d, release_d;
        logic                 sync_n;

        assign sync_n = sync2_q[i];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q      <= StReleased;
                cnt_q        <= '0;
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
            end else begin
                state_q      <= state_d;
                cnt_q        <= cnt_d;
                press_q[i]   <= press_d;
                release_q[i] <= release_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                StReleased: begin
                    if (!sync_n) begin
                        state_d = StWaitPress;
                        cnt_d   = CntOne;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StWaitPress: begin
                    if (sync_n) begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StPressed: begin
                    if (sync_n) begin
                        state_d = StWaitRelease;
                        cnt_d   = CntOne;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StWaitRelease: begin
                    if (!sync_n) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d   = StReleased;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level[i]  = (state_q == StPressed) || (state_q == StWaitRelease);
        assign cnt_nz[i] = (cnt_q != '0);
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.busy        = |cnt_nz;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_COUNT=4: edge-numbered checks of
// level, pulses and busy for clean press, short glitch, bounce, release, reset abort, all-press.
module tb_button_debouncer;
    logic clock;
    logic reset;
    int   tests;
    int   fails;
    int   npress;

    button_debouncer_if #(.N_BTN(3)) bus ();

    button_debouncer #(
        .N_BTN       (3),
        .CNT_WIDTH   (16),
        .STABLE_COUNT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(bus.btn_level), 0);
        chk({tag, "_press"}, 32'(bus.btn_press), 0);
        chk({tag, "_release"}, 32'(bus.btn_release), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.btn_raw_n = 3'b111;
        tick();
        chk_all_zero("reset");
        #2 reset = 1'b0;
        repeat (3) tick();
        chk_all_zero("idle");

        // Clean press on channel 0: pulse and level at edge 5, busy at edges 2-4
        bus.btn_raw_n[0] = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("p0_busy_e%0d", e), 32'(bus.busy), (e >= 2 && e <= 4) ? 1 : 0);
            chk($sformatf("p0_press_e%0d", e), 32'(bus.btn_press), (e == 5) ? 1 : 0);
            chk($sformatf("p0_level_e%0d", e), 32'(bus.btn_level), (e >= 5) ? 1 : 0);
        end

        // Three-cycle glitch on channel 1 must be rejected
        bus.btn_raw_n[1] = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 2) bus.btn_raw_n[1] = 1'b1;
            chk($sformatf("g1_level_e%0d", e), 32'(bus.btn_level), 32'h1);
            chk($sformatf("g1_press_e%0d", e), 32'(bus.btn_press), 0);
            chk($sformatf("g1_rel_e%0d", e), 32'(bus.btn_release), 0);
            chk($sformatf("g1_busy_e%0d", e), 32'(bus.busy), (e >= 2 && e <= 4) ? 1 : 0);
        end

        // Bounce low,high,low... on channel 2: one press timed from the final low run
        npress = 0;
        bus.btn_raw_n[2] = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 0) bus.btn_raw_n[2] = 1'b1;
            if (e == 1) bus.btn_raw_n[2] = 1'b0;
            if (bus.btn_press[2] === 1'b1) npress++;
            chk($sformatf("b2_press_e%0d", e), 32'(bus.btn_press), (e == 7) ? 32'h4 : 0);
            chk($sformatf("b2_level_e%0d", e), 32'(bus.btn_level), (e >= 7) ? 32'h5 : 32'h1);
            chk($sformatf("b2_busy_e%0d", e), 32'(bus.busy),
                (e == 2 || (e >= 4 && e <= 6)) ? 1 : 0);
        end
        chk("b2_press_count", 32'(npress), 1);

        // Release channel 0
        bus.btn_raw_n[0] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("r0_rel_e%0d", e), 32'(bus.btn_release), (e == 5) ? 1 : 0);
            chk($sformatf("r0_press_e%0d", e), 32'(bus.btn_press), 0);
            chk($sformatf("r0_level_e%0d", e), 32'(bus.btn_level), (e >= 5) ? 32'h4 : 32'h5);
        end

        // Reset between edges while channel 1 is counting and channel 2 is held pressed
        bus.btn_raw_n[1] = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", 32'(bus.busy), 1);
        chk("pre_rst_level", 32'(bus.btn_level), 32'h4);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        chk_all_zero("in_rst");
        #2 reset = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("ar_press_e%0d", e), 32'(bus.btn_press), (e == 5) ? 32'h6 : 0);
            chk($sformatf("ar_level_e%0d", e), 32'(bus.btn_level), (e >= 5) ? 32'h6 : 0);
            chk($sformatf("ar_busy_e%0d", e), 32'(bus.busy), (e >= 2 && e <= 4) ? 1 : 0);
        end

        // Release everything, then press all three together
        bus.btn_raw_n = 3'b111;
        repeat (8) tick();
        chk_all_zero("all_idle");
        bus.btn_raw_n = 3'b000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("all_press_e%0d", e), 32'(bus.btn_press), (e == 5) ? 32'h7 : 0);
            chk($sformatf("all_level_e%0d", e), 32'(bus.btn_level), (e >= 5) ? 32'h7 : 0);
        end
        bus.btn_raw_n = 3'b111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("all_rel_e%0d", e), 32'(bus.btn_release), (e == 5) ? 32'h7 : 0);
            chk($sformatf("all_rlevel_e%0d", e), 32'(bus.btn_level), (e >= 5) ? 0 : 32'h7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
